// File: rtl/dual_core_dispatch_scheduler_if.sv
// dual_core_dispatch_scheduler_if: instruction stream in, two core FIFO streams out.
// Ports: in_valid/in_instr/in_ready (stream), ck_valid/ck_instr/ck_ready (core k FIFO),
// ck_done (core k retire pulse). slave = scheduler side, master = environment side.
interface dual_core_dispatch_scheduler_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        c0_valid;
  logic [31:0] c0_instr;
  logic        c0_ready;
  logic        c0_done;
  logic        c1_valid;
  logic [31:0] c1_instr;
  logic        c1_ready;
  logic        c1_done;
  modport master (
    output in_valid, in_instr, c0_ready, c0_done, c1_ready, c1_done,
    input  in_ready, c0_valid, c0_instr, c1_valid, c1_instr
  );
  modport slave (
    input  in_valid, in_instr, c0_ready, c0_done, c1_ready, c1_done,
    output in_ready, c0_valid, c0_instr, c1_valid, c1_instr
  );
endinterface

// File: rtl/dual_core_dispatch_scheduler.sv
// dual_core_dispatch_scheduler: hazard-aware dispatch of one instruction stream to two cores.
// Ports: clk, resetn (sync, active-low), bus (slave modport: stream in, two core FIFOs out),
// stall_cnt (cycles stalled, saturating), drop_cnt (discarded no-ops, saturating).
module dual_core_dispatch_scheduler #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  dual_core_dispatch_scheduler_if.slave bus,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [11:0]      src_q [2][DEPTH];
  logic [11:0]      dst_q [2][DEPTH];
  logic [DEPTH-1:0] ent_v [2];
  logic [PW-1:0]    head [2];
  logic [PW-1:0]    tail [2];
  logic [CW-1:0]    cnt [2];
  logic [31:0]      ci [2];
  logic [1:0]       cv, rdy, done, hit, push, pop;
  logic [11:0]      s_tag, d_tag;
  logic             rr, drop, tgt, acc, in_ready, dispatch;
  assign rdy  = {bus.c1_ready, bus.c0_ready};
  assign done = {bus.c1_done, bus.c0_done};
  assign bus.in_ready = in_ready;
  assign bus.c0_valid = cv[0];
  assign bus.c1_valid = cv[1];
  assign bus.c0_instr = ci[0];
  assign bus.c1_instr = ci[1];
  always_comb begin
    s_tag = {bus.in_instr[23], bus.in_instr[10:0]};
    d_tag = {bus.in_instr[22], bus.in_instr[21:11]};
    drop  = bus.in_instr[23] & bus.in_instr[22];
    hit   = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++)
        hit[k] = hit[k] | (ent_v[k][i] &
                 (s_tag == dst_q[k][i] || d_tag == src_q[k][i] || d_tag == dst_q[k][i]));
    tgt      = hit[0] ? 1'b0 : hit[1] ? 1'b1 : rr;
    acc      = (cnt[tgt] < FULL) && (!cv[tgt] || rdy[tgt]);
    in_ready = drop || (!(&hit) && acc);
    dispatch = bus.in_valid && in_ready && !drop;
    push     = dispatch ? (tgt ? 2'b10 : 2'b01) : 2'b00;
    pop[0]   = done[0] && cnt[0] != '0;
    pop[1]   = done[1] && cnt[1] != '0;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        ent_v[k] <= '0;
        head[k]  <= '0;
        tail[k]  <= '0;
        cnt[k]   <= '0;
        ci[k]    <= '0;
      end
      cv        <= '0;
      rr        <= 1'b0;
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (pop[k]) begin
          ent_v[k][head[k]] <= 1'b0;
          head[k]           <= head[k] == LAST ? '0 : head[k] + 1'b1;
        end
        // A push never targets a full core, so it cannot land on the slot being popped.
        if (push[k]) begin
          ent_v[k][tail[k]] <= 1'b1;
          src_q[k][tail[k]] <= s_tag;
          dst_q[k][tail[k]] <= d_tag;
          tail[k]           <= tail[k] == LAST ? '0 : tail[k] + 1'b1;
          ci[k]             <= bus.in_instr;
        end
        cnt[k] <= cnt[k] + CW'(push[k]) - CW'(pop[k]);
        cv[k]  <= push[k] | (cv[k] & ~rdy[k]);
      end
      // Only independent dispatches advance round-robin.
      if (dispatch && !(|hit))
        rr <= ~rr;
      if (bus.in_valid && !in_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if (bus.in_valid && drop && !(&drop_cnt))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_dual_core_dispatch_scheduler.sv
// tb_dual_core_dispatch_scheduler: directed self-checking bench for the dispatcher.
module tb_dual_core_dispatch_scheduler;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] stall_cnt, drop_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  dual_core_dispatch_scheduler_if bus();
  dual_core_dispatch_scheduler #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mk(input logic [10:0] dst, input logic [10:0] src);
    return {10'b0, dst, src};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic put(input logic [31:0] ins);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    #1;
  endtask
  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    #1;
  endtask
  task automatic retire(input logic [1:0] m, input int n);
    bus.c0_done = m[0];
    bus.c1_done = m[1];
    repeat (n) tick();
    bus.c0_done = 1'b0;
    bus.c1_done = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.c0_ready = 1'b1;
    bus.c1_ready = 1'b1;
    bus.c0_done  = 1'b0;
    bus.c1_done  = 1'b0;
    tick();
    tick();
    chk("rst_c0v", 32'(bus.c0_valid), 0);
    chk("rst_c1v", 32'(bus.c1_valid), 0);
    chk("rst_c0i", bus.c0_instr, 0);
    chk("rst_c1i", bus.c1_instr, 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    resetn = 1'b1;
    // Independent instructions alternate 0,1,0,1 with one-cycle latency.
    put(mk(11'h100, 11'h101));
    chk("t1_rdy", 32'(bus.in_ready), 1);
    chk("t1_lat", 32'(bus.c0_valid), 0);
    tick();
    chk("t1_a_c0v", 32'(bus.c0_valid), 1);
    chk("t1_a_c0i", bus.c0_instr, mk(11'h100, 11'h101));
    chk("t1_a_c1v", 32'(bus.c1_valid), 0);
    put(mk(11'h102, 11'h103));
    tick();
    chk("t1_b_c1v", 32'(bus.c1_valid), 1);
    chk("t1_b_c1i", bus.c1_instr, mk(11'h102, 11'h103));
    chk("t1_b_c0v", 32'(bus.c0_valid), 0);
    put(mk(11'h104, 11'h105));
    tick();
    chk("t1_c_c0i", bus.c0_instr, mk(11'h104, 11'h105));
    chk("t1_c_c1v", 32'(bus.c1_valid), 0);
    put(mk(11'h106, 11'h107));
    tick();
    chk("t1_d_c1v", 32'(bus.c1_valid), 1);
    chk("t1_d_c1i", bus.c1_instr, mk(11'h106, 11'h107));
    idle();
    tick();
    chk("t1_clr_c0v", 32'(bus.c0_valid), 0);
    chk("t1_clr_c1v", 32'(bus.c1_valid), 0);
    retire(2'b11, 2);
    // Dependency follows the producer's core even when rr points elsewhere.
    put(mk(11'h005, 11'h200));
    tick();
    chk("t2_a_c0v", 32'(bus.c0_valid), 1);
    put(mk(11'h201, 11'h005));
    tick();
    chk("t2_b_c0i", bus.c0_instr, mk(11'h201, 11'h005));
    chk("t2_b_c1v", 32'(bus.c1_valid), 0);
    put(mk(11'h300, 11'h301));
    tick();
    chk("t2_rr_c1i", bus.c1_instr, mk(11'h300, 11'h301));
    chk("t2_rr_c0v", 32'(bus.c0_valid), 0);
    idle();
    retire(2'b11, 2);
    // Dual hit stalls until core 1 retires; the retire cycle itself still stalls.
    put(mk(11'h010, 11'h400));
    tick();
    put(mk(11'h020, 11'h401));
    tick();
    chk("t3_y_c1i", bus.c1_instr, mk(11'h020, 11'h401));
    put(mk(11'h020, 11'h010));
    chk("t3_rdy0", 32'(bus.in_ready), 0);
    tick();
    tick();
    chk("t3_stall2", 32'(stall_cnt), 2);
    bus.c1_done = 1'b1;
    #1;
    chk("t3_rdy_done", 32'(bus.in_ready), 0);
    tick();
    bus.c1_done = 1'b0;
    #1;
    chk("t3_rdy1", 32'(bus.in_ready), 1);
    chk("t3_stall3", 32'(stall_cnt), 3);
    tick();
    chk("t3_c0v", 32'(bus.c0_valid), 1);
    chk("t3_c0i", bus.c0_instr, mk(11'h020, 11'h010));
    chk("t3_c1v", 32'(bus.c1_valid), 0);
    idle();
    retire(2'b01, 2);
    // Depth limit on core 0 and push+pop in the same cycle.
    put(mk(11'h050, 11'h500));
    tick();
    put(mk(11'h051, 11'h050));
    tick();
    put(mk(11'h052, 11'h051));
    tick();
    put(mk(11'h053, 11'h052));
    tick();
    chk("t4_p4_c0i", bus.c0_instr, mk(11'h053, 11'h052));
    put(mk(11'h054, 11'h053));
    chk("t4_full_rdy", 32'(bus.in_ready), 0);
    tick();
    bus.c0_done = 1'b1;
    #1;
    chk("t4_done_rdy", 32'(bus.in_ready), 0);
    tick();
    bus.c0_done = 1'b0;
    #1;
    chk("t4_freed_rdy", 32'(bus.in_ready), 1);
    tick();
    chk("t4_p5_c0i", bus.c0_instr, mk(11'h054, 11'h053));
    put(mk(11'h055, 11'h054));
    chk("t4_p6_rdy0", 32'(bus.in_ready), 0);
    bus.c0_done = 1'b1;
    tick();
    chk("t4_p6_rdy1", 32'(bus.in_ready), 1);
    tick();
    bus.c0_done = 1'b0;
    chk("t4_p6_c0i", bus.c0_instr, mk(11'h055, 11'h054));
    put(mk(11'h056, 11'h055));
    chk("t4_p7_rdy", 32'(bus.in_ready), 1);
    tick();
    put(mk(11'h057, 11'h056));
    chk("t4_p8_rdy0", 32'(bus.in_ready), 0);
    chk("t4_stall", 32'(stall_cnt), 6);
    idle();
    retire(2'b01, 4);
    // Backpressure on core 1 holds its output and blocks the next core-1 instruction.
    bus.c1_ready = 1'b0;
    put(mk(11'h600, 11'h601));
    tick();
    chk("t5_c1v", 32'(bus.c1_valid), 1);
    put(mk(11'h602, 11'h600));
    chk("t5_rdy0", 32'(bus.in_ready), 0);
    tick();
    chk("t5_hold_c1v", 32'(bus.c1_valid), 1);
    chk("t5_hold_c1i", bus.c1_instr, mk(11'h600, 11'h601));
    bus.c1_ready = 1'b1;
    #1;
    chk("t5_rdy1", 32'(bus.in_ready), 1);
    tick();
    chk("t5_reload_c1v", 32'(bus.c1_valid), 1);
    chk("t5_reload_c1i", bus.c1_instr, mk(11'h602, 11'h600));
    idle();
    tick();
    chk("t5_clr_c1v", 32'(bus.c1_valid), 0);
    // Drop, then reset while stalled.
    put(32'h00C0_0000);
    chk("t6_drop_rdy", 32'(bus.in_ready), 1);
    tick();
    chk("t6_drop_cnt", 32'(drop_cnt), 1);
    chk("t6_drop_c0v", 32'(bus.c0_valid), 0);
    chk("t6_drop_c1v", 32'(bus.c1_valid), 0);
    put(mk(11'h700, 11'h701));
    tick();
    chk("t6_w_c0i", bus.c0_instr, mk(11'h700, 11'h701));
    put(mk(11'h700, 11'h602));
    chk("t6_dual_rdy", 32'(bus.in_ready), 0);
    tick();
    resetn = 1'b0;
    tick();
    chk("t6_rst_c0v", 32'(bus.c0_valid), 0);
    chk("t6_rst_c1v", 32'(bus.c1_valid), 0);
    chk("t6_rst_c0i", bus.c0_instr, 0);
    chk("t6_rst_c1i", bus.c1_instr, 0);
    chk("t6_rst_stall", 32'(stall_cnt), 0);
    chk("t6_rst_drop", 32'(drop_cnt), 0);
    resetn = 1'b1;
    #1;
    chk("t6_post_rdy", 32'(bus.in_ready), 1);
    tick();
    chk("t6_post_c0v", 32'(bus.c0_valid), 1);
    chk("t6_post_c0i", bus.c0_instr, mk(11'h700, 11'h602));
    chk("t6_post_c1v", 32'(bus.c1_valid), 0);
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
